// File: rtl/rle_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rle_pkg : shared constants for the 8x8 run-length block decoder    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package rle_pkg;

  localparam int PIX_PER_BLK  = 64;
  localparam int IDX_W        = 6;
  localparam int WORD_W       = 32;
  localparam int HALF_PER_ROW = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  // Bit offset of PIO word lineR_H inside the flattened block.
  function automatic int line_word_lsb(input int row, input int half);
    return row * WORD_W * HALF_PER_ROW + half * WORD_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rle_block_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rle_block_buffer : 64-entry pixel register array, flattened read   |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module rle_block_buffer
  import rle_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_we,
  input  logic [IDX_W-1:0]             i_addr,
  input  logic [PIX_W-1:0]             i_data,
  output logic [PIX_PER_BLK*PIX_W-1:0] o_flat
);

  logic [PIX_W-1:0] r_mem [PIX_PER_BLK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIX_PER_BLK; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_data;
    end
  end

  generate
    for (genvar g = 0; g < PIX_PER_BLK; g++) begin : g_flat
      assign o_flat[g*PIX_W +: PIX_W] = r_mem[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rle_block_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rle_block_decoder : rebuilds an 8x8 pixel block from (value,run)   |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module rle_block_decoder
  import rle_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int BLK_DIM = 8,
  parameter int RUN_W   = 8
) (
  input  logic                             clk_clk,
  input  logic                             reset_reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PIX_W-1:0]                 in_value,
  input  logic [RUN_W-1:0]                 in_run,
  output logic [BLK_DIM*BLK_DIM*PIX_W-1:0] block_data,
  output logic                             block_valid,
  input  logic                             block_ack,
  output logic                             err_overflow,
  output logic                             err_zero_run,
  output logic [7:0]                       block_count
);

  localparam logic [IDX_W:0]   c_blk_pix = 7'd64;
  localparam logic [RUN_W-1:0] c_run_one = RUN_W'(1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [RUN_W-1:0] r_rem;
  logic [PIX_W-1:0] r_val;
  logic             r_ovf;
  logic             r_zero;
  logic [7:0]       r_count;

  logic             w_accept;
  logic             w_last;
  logic             w_we;
  logic [PIX_W-1:0] w_wdata;
  logic [IDX_W:0]   w_remaining;
  logic             w_run_exceeds;

  assign in_ready     = (r_state == S_FILL);
  assign block_valid  = (r_state == S_HOLD);
  assign err_overflow = r_ovf;
  assign err_zero_run = r_zero;
  assign block_count  = r_count;

  assign w_accept      = in_valid & in_ready;
  assign w_last        = (r_idx == LAST_IDX);
  assign w_remaining   = c_blk_pix - {1'b0, r_idx};
  assign w_run_exceeds = ({1'b0, in_run} > {{(RUN_W-IDX_W){1'b0}}, w_remaining});

  always_comb begin
    w_we    = 1'b0;
    w_wdata = r_val;
    if (r_state == S_FILL && w_accept && in_run != '0) begin
      w_we    = 1'b1;
      w_wdata = in_value;
    end else if (r_state == S_EXPAND) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_rem   <= '0;
      r_val   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_count <= '0;
    end else begin
      r_zero <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (in_run == '0) begin
              r_zero <= 1'b1;
            end else begin
              r_val <= in_value;
              // Truncation is known at accept time; the excess is simply never expanded.
              if (w_run_exceeds) begin
                r_ovf <= 1'b1;
              end
              if (w_last) begin
                r_state <= S_HOLD;
              end else begin
                r_idx <= r_idx + 6'd1;
                if (in_run > c_run_one) begin
                  r_rem   <= in_run - c_run_one;
                  r_state <= S_EXPAND;
                end
              end
            end
          end
        end
        S_EXPAND: begin
          if (w_last) begin
            r_state <= S_HOLD;
          end else begin
            r_idx <= r_idx + 6'd1;
            r_rem <= r_rem - c_run_one;
            if (r_rem == c_run_one) begin
              r_state <= S_FILL;
            end
          end
        end
        S_HOLD: begin
          if (block_ack) begin
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_count <= r_count + 8'd1;
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  rle_block_buffer #(
    .PIX_W (PIX_W)
  ) u_buf (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .i_we   (w_we),
    .i_addr (r_idx),
    .i_data (w_wdata),
    .o_flat (block_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rle_block_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rle_block_decoder : directed self-checking bench                |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_rle_block_decoder;

  logic         clk_clk = 1'b0;
  logic         reset_reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_value = '0;
  logic [7:0]   in_run = '0;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_ack = 1'b0;
  logic         err_overflow;
  logic         err_zero_run;
  logic [7:0]   block_count;

  int n_cmp = 0;
  int n_bad = 0;

  rle_block_decoder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_run        (in_run),
    .block_data    (block_data),
    .block_valid   (block_valid),
    .block_ack     (block_ack),
    .err_overflow  (err_overflow),
    .err_zero_run  (err_zero_run),
    .block_count   (block_count)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [7:0] pix(input int p);
    return block_data[p*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Presents one pair, waits (bounded) for in_ready, completes the handshake.
  task automatic send_pair(input logic [7:0] v, input logic [7:0] r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_value = v;
    in_run   = r;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      n_bad++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Counts observed cycles with in_ready low and block_valid low (EXPAND), bounded.
  task automatic count_expand(output int cyc);
    cyc = 0;
    while (!in_ready && !block_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_ack();
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    tick();
    tick();
    reset_reset_n = 1'b1;
    tick();
    n_cmp++;
    if (block_valid !== 1'b0 || err_overflow !== 1'b0 || err_zero_run !== 1'b0) begin
      $display("FAIL reset_flags: got valid=%b ovf=%b zero=%b, required 0 0 0",
               block_valid, err_overflow, err_zero_run);
      n_bad++;
    end
    n_cmp++;
    if (block_count !== 8'd0) begin
      $display("FAIL reset_count: got %0d, required 0", block_count);
      n_bad++;
    end
    n_cmp++;
    if (block_data !== 512'd0) begin
      $display("FAIL reset_data: got nonzero buffer, required all 0");
      n_bad++;
    end
  endtask

  task automatic test_sequential_fill();
    int low_ready;
    low_ready = 0;
    in_valid = 1'b1;
    in_run   = 8'd1;
    for (int p = 0; p < 64; p++) begin
      in_value = 8'(p);
      if (!in_ready) low_ready++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (low_ready !== 0) begin
      $display("FAIL seq_ready: in_ready low in %0d of 64 cycles, required 0", low_ready);
      n_bad++;
    end
    n_cmp++;
    if (block_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL seq_valid: got valid=%b ready=%b, required 1 0", block_valid, in_ready);
      n_bad++;
    end
    for (int p = 0; p < 64; p++) begin
      n_cmp++;
      if (pix(p) !== 8'(p)) begin
        $display("FAIL seq_pix%0d: got %h, required %h", p, pix(p), 8'(p));
        n_bad++;
      end
    end
    n_cmp++;
    if (block_data[31:0] !== 32'h03020100) begin
      $display("FAIL seq_line0_0: got %h, required 03020100", block_data[31:0]);
      n_bad++;
    end
    n_cmp++;
    if (block_data[96 +: 32] !== 32'h0F0E0D0C) begin
      $display("FAIL seq_line1_1: got %h, required 0f0e0d0c", block_data[96 +: 32]);
      n_bad++;
    end
  endtask

  task automatic test_hold_backpressure();
    logic [511:0] snap;
    snap = block_data;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_value = 8'hE0 + 8'(i);
      in_run   = 8'd1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        $display("FAIL hold_ready%0d: got %b, required 0", i, in_ready);
        n_bad++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (block_data !== snap || block_valid !== 1'b1) begin
      $display("FAIL hold_frozen: data changed or valid=%b, required frozen and 1", block_valid);
      n_bad++;
    end
    n_cmp++;
    if (block_count !== 8'd0) begin
      $display("FAIL hold_count_pre: got %0d, required 0", block_count);
      n_bad++;
    end
    do_ack();
    n_cmp++;
    if (block_valid !== 1'b0 || block_count !== 8'd1 || in_ready !== 1'b1) begin
      $display("FAIL hold_ack: got valid=%b count=%0d ready=%b, required 0 1 1",
               block_valid, block_count, in_ready);
      n_bad++;
    end
  endtask

  task automatic test_two_runs();
    int cyc;
    send_pair(8'hAA, 8'd16);
    count_expand(cyc);
    n_cmp++;
    if (cyc !== 15) begin
      $display("FAIL run16_stall: got %0d cycles, required 15", cyc);
      n_bad++;
    end
    send_pair(8'h55, 8'd48);
    count_expand(cyc);
    n_cmp++;
    if (cyc !== 47 || block_valid !== 1'b1) begin
      $display("FAIL run48_stall: got %0d cycles valid=%b, required 47 1", cyc, block_valid);
      n_bad++;
    end
    for (int p = 0; p < 64; p++) begin
      n_cmp++;
      if (pix(p) !== ((p < 16) ? 8'hAA : 8'h55)) begin
        $display("FAIL runs_pix%0d: got %h, required %h", p, pix(p), (p < 16) ? 8'hAA : 8'h55);
        n_bad++;
      end
    end
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      $display("FAIL runs_ovf: got %b, required 0", err_overflow);
      n_bad++;
    end
    do_ack();
  endtask

  task automatic test_overflow();
    int cyc;
    send_pair(8'h11, 8'd60);
    count_expand(cyc);
    send_pair(8'h22, 8'd10);
    count_expand(cyc);
    n_cmp++;
    if (block_valid !== 1'b1 || err_overflow !== 1'b1) begin
      $display("FAIL ovf_hold: got valid=%b ovf=%b, required 1 1", block_valid, err_overflow);
      n_bad++;
    end
    for (int p = 58; p < 64; p++) begin
      n_cmp++;
      if (pix(p) !== ((p < 60) ? 8'h11 : 8'h22)) begin
        $display("FAIL ovf_pix%0d: got %h, required %h", p, pix(p), (p < 60) ? 8'h11 : 8'h22);
        n_bad++;
      end
    end
    do_ack();
    n_cmp++;
    if (err_overflow !== 1'b0 || in_ready !== 1'b1 || block_count !== 8'd3) begin
      $display("FAIL ovf_after_ack: got ovf=%b ready=%b count=%0d, required 0 1 3",
               err_overflow, in_ready, block_count);
      n_bad++;
    end
  endtask

  task automatic test_zero_run();
    int cyc;
    send_pair(8'h33, 8'd5);
    count_expand(cyc);
    send_pair(8'h7F, 8'd0);
    n_cmp++;
    if (err_zero_run !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL zero_pulse: got zero=%b ready=%b, required 1 1", err_zero_run, in_ready);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (err_zero_run !== 1'b0) begin
      $display("FAIL zero_pulse_width: got %b, required 0", err_zero_run);
      n_bad++;
    end
    send_pair(8'h01, 8'd1);
    send_pair(8'h44, 8'd58);
    count_expand(cyc);
    n_cmp++;
    if (pix(0) !== 8'h33 || pix(4) !== 8'h33 || pix(5) !== 8'h01 || pix(6) !== 8'h44) begin
      $display("FAIL zero_idx: got p0=%h p4=%h p5=%h p6=%h, required 33 33 01 44",
               pix(0), pix(4), pix(5), pix(6));
      n_bad++;
    end
    n_cmp++;
    if (block_valid !== 1'b1 || err_overflow !== 1'b0 || pix(63) !== 8'h44) begin
      $display("FAIL zero_complete: got valid=%b ovf=%b p63=%h, required 1 0 44",
               block_valid, err_overflow, pix(63));
      n_bad++;
    end
    // Ack raised in the same cycle block_valid is first seen is still honoured.
    do_ack();
    n_cmp++;
    if (block_count !== 8'd4 || block_valid !== 1'b0) begin
      $display("FAIL zero_ack: got count=%0d valid=%b, required 4 0", block_count, block_valid);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_expand();
    send_pair(8'h66, 8'd30);
    for (int i = 0; i < 19; i++) tick();
    n_cmp++;
    if (in_ready !== 1'b0 || pix(19) !== 8'h66) begin
      $display("FAIL rst_pre: got ready=%b p19=%h, required 0 66", in_ready, pix(19));
      n_bad++;
    end
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    n_cmp++;
    if (block_data !== 512'd0 || block_count !== 8'd0 || block_valid !== 1'b0 ||
        err_overflow !== 1'b0 || err_zero_run !== 1'b0) begin
      $display("FAIL rst_mid: got count=%0d valid=%b ovf=%b p0=%h, required all 0",
               block_count, block_valid, err_overflow, pix(0));
      n_bad++;
    end
    send_pair(8'h5A, 8'd1);
    n_cmp++;
    if (pix(0) !== 8'h5A || pix(1) !== 8'h00 || in_ready !== 1'b1) begin
      $display("FAIL rst_next: got p0=%h p1=%h ready=%b, required 5a 00 1",
               pix(0), pix(1), in_ready);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential_fill();
    test_hold_backpressure();
    test_two_runs();
    test_overflow();
    test_zero_run();
    test_reset_mid_expand();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
